// File: rtl/ig_stream_grad_pkg.sv
// +-----------------------------------------------------------------+
// | ig_pkg : shared types and helpers for the streaming gradient    |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
`default_nettype none

package ig_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic MODE_PACK = 1'b0;
  localparam logic MODE_L1   = 1'b1;

  // Two extra bits hold the sign and the range of a difference of unsigned pixels.
  function automatic int grad_width(input int dw);
    return dw + 2;
  endfunction

  // Places gx above gy, each masked to gw bits; the caller truncates to 2*gw.
  function automatic logic [63:0] pack_grad(input logic [31:0] gx,
                                            input logic [31:0] gy,
                                            input int          gw);
    logic [63:0] m;
    m = (64'd1 << gw) - 64'd1;
    return (({32'd0, gx} & m) << gw) | ({32'd0, gy} & m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ig_stream_grad_line_buf.sv
// +-----------------------------------------------------------------+
// | ig_line_buf : circular delay line giving taps at DEPTH, DEPTH-1 |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
`default_nettype none

module ig_line_buf
  import ig_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] tap_w_o,
  output logic [DW-1:0] tap_w1_o
);

  localparam int c_PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0]   mem_q [DEPTH];
  logic [c_PW-1:0] ptr_q;
  logic [c_PW-1:0] w_ptr_nx;

  assign w_ptr_nx = (ptr_q == c_PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (en_i) begin
      ptr_q <= w_ptr_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      mem_q[ptr_q] <= din_i;
    end
  end

  // The slot about to be overwritten is DEPTH old; the next one is DEPTH-1 old.
  assign tap_w_o  = mem_q[ptr_q];
  assign tap_w1_o = mem_q[w_ptr_nx];

endmodule

`default_nettype wire

// File: rtl/ig_stream_grad.sv
// +-----------------------------------------------------------------+
// | ig_stream_grad : raster-order image gradient, packed or L1 mag  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
`default_nettype none

module ig_stream_grad
  import ig_pkg::*;
#(
  parameter int IMG_W = 256,
  parameter int IMG_H = 256,
  parameter int DW    = 8,
  parameter int AW    = 16,
  parameter int GW    = grad_width(DW)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            mode,
  output logic            busy,
  output logic            done,
  output logic            img_rd,
  output logic            img_wr,
  output logic [AW-1:0]   img_addr,
  input  logic [DW-1:0]   img_di,
  output logic [DW-1:0]   img_do,
  output logic            grad_wr,
  output logic            grad_rd,
  output logic [AW-1:0]   grad_addr,
  output logic [2*GW-1:0] grad_do,
  input  logic [2*GW-1:0] grad_di
);

  localparam int c_N   = IMG_W * IMG_H;
  localparam int c_SW  = $clog2(c_N + IMG_W);
  localparam int c_CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int c_OW  = 2 * GW;

  localparam logic [AW-1:0]   c_LAST_ADDR = AW'(c_N - 1);
  localparam logic [c_SW-1:0] c_S_N       = c_SW'(c_N);
  localparam logic [c_SW-1:0] c_S_W       = c_SW'(IMG_W);
  localparam logic [c_SW-1:0] c_S_LAST    = c_SW'(c_N + IMG_W - 1);
  localparam logic [c_CW-1:0] c_COL_LAST  = c_CW'(IMG_W - 1);
  localparam logic [c_RW-1:0] c_ROW_LAST  = c_RW'(IMG_H - 1);

  state_t state_q, state_d;

  logic            mode_q;
  logic [AW-1:0]   rd_cnt_q;
  logic            en_q, en_d;
  logic [c_SW-1:0] s_q;
  logic [c_CW-1:0] col_q;
  logic [c_RW-1:0] row_q;
  logic [AW-1:0]   wa_q;
  logic            grad_wr_q;
  logic [AW-1:0]   grad_addr_q;
  logic [c_OW-1:0] grad_do_q;

  logic                 w_s_last;
  logic                 w_emit;
  logic [DW-1:0]        w_pix;
  logic [DW-1:0]        w_tap_w;
  logic [DW-1:0]        w_tap_w1;
  logic signed [GW-1:0] w_prc, w_prc1, w_pr1c;
  logic signed [GW-1:0] w_gx, w_gy;
  logic [GW-1:0]        w_ax, w_ay, w_mag;
  logic [c_OW-1:0]      w_word;
  logic                 w_unused;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (rd_cnt_q == c_LAST_ADDR) state_d = ST_FLUSH;
      ST_FLUSH: if (grad_wr_q && (grad_addr_q == c_LAST_ADDR)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q != ST_IDLE);
    done   = (state_q == ST_DONE);
    img_rd = (state_q == ST_READ);
  end

  // Stream index s counts line-buffer shifts: N real pixels, then W zeros.
  assign w_s_last = (s_q == c_S_LAST);
  assign en_d     = (state_q == ST_READ) || (en_q && !w_s_last);
  assign w_emit   = en_q && (s_q >= c_S_W);
  assign w_pix    = (s_q < c_S_N) ? img_di : '0;

  ig_line_buf #(
    .DEPTH (IMG_W),
    .DW    (DW)
  ) u_line_buf (
    .clk      (clk),
    .reset    (reset),
    .en_i     (en_q),
    .din_i    (w_pix),
    .tap_w_o  (w_tap_w),
    .tap_w1_o (w_tap_w1)
  );

  assign w_prc  = {{(GW-DW){1'b0}}, w_tap_w};
  assign w_prc1 = {{(GW-DW){1'b0}}, w_tap_w1};
  assign w_pr1c = {{(GW-DW){1'b0}}, w_pix};
  assign w_gx   = (col_q == c_COL_LAST) ? '0 : (w_prc1 - w_prc);
  assign w_gy   = (row_q == c_ROW_LAST) ? '0 : (w_pr1c - w_prc);
  assign w_ax   = w_gx[GW-1] ? GW'(-w_gx) : GW'(w_gx);
  assign w_ay   = w_gy[GW-1] ? GW'(-w_gy) : GW'(w_gy);
  assign w_mag  = w_ax + w_ay;
  assign w_word = (mode_q == MODE_L1) ? {{GW{1'b0}}, w_mag}
                                      : c_OW'(pack_grad(32'(w_gx), 32'(w_gy), GW));

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= MODE_PACK;
      rd_cnt_q    <= '0;
      en_q        <= 1'b0;
      s_q         <= '0;
      col_q       <= '0;
      row_q       <= '0;
      wa_q        <= '0;
      grad_wr_q   <= 1'b0;
      grad_addr_q <= '0;
      grad_do_q   <= '0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        mode_q <= mode;
      end
      if (state_q == ST_READ) begin
        rd_cnt_q <= (rd_cnt_q == c_LAST_ADDR) ? '0 : rd_cnt_q + 1'b1;
      end
      en_q      <= en_d;
      s_q       <= (en_q && !w_s_last) ? s_q + 1'b1 : '0;
      grad_wr_q <= w_emit;
      if (w_emit) begin
        grad_addr_q <= wa_q;
        grad_do_q   <= w_word;
        wa_q        <= (wa_q == c_LAST_ADDR) ? '0 : wa_q + 1'b1;
        if (col_q == c_COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == c_ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  assign img_addr  = rd_cnt_q;
  assign grad_wr   = grad_wr_q;
  assign grad_addr = grad_addr_q;
  assign grad_do   = grad_do_q;
  assign img_wr    = 1'b0;
  assign img_do    = '0;
  assign grad_rd   = 1'b0;
  assign w_unused  = ^grad_di;

endmodule

`default_nettype wire
